// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op bit indices,
// FSM state type and a small sign helper.
package hilo_mdu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 8;

  localparam int HILO_OP_MULT  = 0;
  localparam int HILO_OP_MULTU = 1;
  localparam int HILO_OP_DIV   = 2;
  localparam int HILO_OP_DIVU  = 3;
  localparam int HILO_OP_MFHI  = 4;
  localparam int HILO_OP_MFLO  = 5;
  localparam int HILO_OP_MTHI  = 6;
  localparam int HILO_OP_MTLO  = 7;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_DONE
  } mdu_state_t;

  function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// EXE-side request/response bundle of the HI/LO sequencer; master is the
// pipeline, slave is the sequencer.
interface hilo_mdu_ctrl_if
  import hilo_mdu_ctrl_pkg::*;
();
  logic              flush;
  logic              req_valid;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              out_allowin;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output flush, req_valid, req_op, src1, src2, out_allowin,
    input  stall, rdata, hi, lo
  );

  modport slave (
    input  flush, req_valid, req_op, src1, src2, out_allowin,
    output stall, rdata, hi, lo
  );
endinterface

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// trial-subtract the divisor and emit one quotient bit.
module hilo_mdu_ctrl_div_iter
  import hilo_mdu_ctrl_pkg::*;
(
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;
  logic              ge;

  // quo_i doubles as the dividend shift register: its MSB is the next bit in
  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign ge      = shifted >= {2'b00, divisor_i};
  assign diff    = shifted - {2'b00, divisor_i};
  assign rem_o   = (DATA_W+1)'(ge ? diff : shifted);
  assign quo_o   = {quo_i[DATA_W-2:0], ge};

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO sequencer for the EXE stage: multi-cycle multiply, iterative divide,
// MTHI/MTLO writes and MFHI/MFLO reads, with flush cancelling in-flight work.
//   state    | meaning
//   MDU_IDLE | no op in flight, accepts requests
//   MDU_MUL  | product latency countdown
//   MDU_DIV  | one restoring iteration per cycle
//   MDU_DONE | result ready, waits for out_allowin to commit
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic            clk,
  input  logic            reset,
  hilo_mdu_ctrl_if.slave  bus
);
  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  mdu_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] opa_q, opb_q, hi_q, lo_q;
  logic [DATA_W:0]   rem_q;
  logic              mul_sgn_q, neg_quo_q, neg_rem_q, is_div_q;

  logic              is_mul, is_div, div_sgn, accept_long;
  logic [DATA_W:0]   rem_d;
  logic [DATA_W-1:0] quo_d, quo_fix, rem_fix;
  logic [63:0]       mul_a, mul_b, prod;

  assign is_mul  = bus.req_op[HILO_OP_MULT] | bus.req_op[HILO_OP_MULTU];
  assign is_div  = bus.req_op[HILO_OP_DIV]  | bus.req_op[HILO_OP_DIVU];
  assign div_sgn = bus.req_op[HILO_OP_DIV];
  assign accept_long = (state_q == MDU_IDLE) && bus.req_valid && (is_mul || is_div);

  assign bus.stall = !bus.flush &&
                     (accept_long || state_q == MDU_MUL || state_q == MDU_DIV);
  assign bus.rdata = (bus.req_valid && bus.req_op[HILO_OP_MFHI]) ? hi_q :
                     (bus.req_valid && bus.req_op[HILO_OP_MFLO]) ? lo_q : '0;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // low 64 bits of the sign-extended product are exact for both MULT and MULTU
  assign mul_a = {{DATA_W{mul_sgn_q & opa_q[DATA_W-1]}}, opa_q};
  assign mul_b = {{DATA_W{mul_sgn_q & opb_q[DATA_W-1]}}, opb_q};
  assign prod  = mul_a * mul_b;

  assign quo_fix = neg_quo_q ? -opa_q : opa_q;
  assign rem_fix = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

  hilo_mdu_ctrl_div_iter u_div_iter (
    .rem_i     (rem_q),
    .quo_i     (opa_q),
    .divisor_i (opb_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_sgn_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (bus.req_valid) begin
            if (is_mul) begin
              opa_q     <= bus.src1;
              opb_q     <= bus.src2;
              mul_sgn_q <= bus.req_op[HILO_OP_MULT];
              is_div_q  <= 1'b0;
              cnt_q     <= CNT_W'(MUL_CYCLES - 1);
              state_q   <= MDU_MUL;
            end else if (is_div) begin
              opa_q     <= abs_if(bus.src1, div_sgn);
              opb_q     <= abs_if(bus.src2, div_sgn);
              neg_quo_q <= div_sgn & (bus.src1[DATA_W-1] ^ bus.src2[DATA_W-1]);
              neg_rem_q <= div_sgn & bus.src1[DATA_W-1];
              rem_q     <= '0;
              is_div_q  <= 1'b1;
              cnt_q     <= CNT_W'(DIV_ITERS - 1);
              state_q   <= MDU_DIV;
            end else if (bus.out_allowin) begin
              if (bus.req_op[HILO_OP_MTHI]) hi_q <= bus.src1;
              if (bus.req_op[HILO_OP_MTLO]) lo_q <= bus.src1;
            end
          end
        end
        MDU_MUL: begin
          if (cnt_q == '0) state_q <= MDU_DONE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        MDU_DIV: begin
          rem_q <= rem_d;
          opa_q <= quo_d;
          if (cnt_q == '0) state_q <= MDU_DONE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        MDU_DONE: begin
          if (bus.out_allowin) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end
            state_q <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: cycle-level reference model plus literal
// expectations for each scenario.
module tb_hilo_mdu_ctrl;
  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic cmp_en = 1'b0;

  hilo_mdu_ctrl_if bus();

  hilo_mdu_ctrl #(.MUL_CYCLES(MUL_LAT), .DIV_ITERS(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Architectural result of a multiply/divide, straight from the ISA rules
  function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    longint      sp;
    if (op == OP_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
    ua = (op == OP_DIV && a[31]) ? -a : a;
    ub = (op == OP_DIV && b[31]) ? -b : b;
    if (ub == 0) begin
      uq = 32'hFFFF_FFFF;
      ur = ua;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (op == OP_DIV && (a[31] ^ b[31])) ? -uq : uq;
    r = (op == OP_DIV && a[31]) ? -ur : ur;
    return {r, q};
  endfunction

  // Reference model: remaining stall cycles after accept, then a pending result
  int          m_busy;
  logic        m_wait;
  logic [63:0] m_res;
  logic [31:0] exp_hi, exp_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_wait = 0; m_res = '0; exp_hi = '0; exp_lo = '0;
    end else if (bus.flush) begin
      m_busy = 0; m_wait = 0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      if (m_busy == 0) m_wait = 1;
    end else if (m_wait) begin
      if (bus.out_allowin) begin
        {exp_hi, exp_lo} = m_res;
        m_wait = 0;
      end
    end else if (bus.req_valid) begin
      if (bus.req_op[3:0] != 0) begin
        m_res  = ref_result(bus.req_op, bus.src1, bus.src2);
        m_busy = (bus.req_op[1:0] != 0) ? MUL_LAT : DIV_LAT;
      end else if (bus.out_allowin) begin
        if (bus.req_op[6]) exp_hi = bus.src1;
        if (bus.req_op[7]) exp_lo = bus.src1;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_rd;
    if (cmp_en) begin
      if (bus.flush)                                    e_stall = 0;
      else if (m_busy > 0)                              e_stall = 1;
      else if (m_wait)                                  e_stall = 0;
      else if (bus.req_valid && bus.req_op[3:0] != 0)   e_stall = 1;
      else                                              e_stall = 0;
      if (bus.req_valid && bus.req_op[4])      e_rd = exp_hi;
      else if (bus.req_valid && bus.req_op[5]) e_rd = exp_lo;
      else                                     e_rd = '0;
      chk("model_stall", {31'd0, bus.stall}, {31'd0, e_stall});
      chk("model_rdata", bus.rdata, e_rd);
      chk("model_hi", bus.hi, exp_hi);
      chk("model_lo", bus.lo, exp_lo);
    end
  end

  task automatic idle_in();
    bus.req_valid   = 1'b0;
    bus.req_op      = '0;
    bus.src1        = '0;
    bus.src2        = '0;
    bus.flush       = 1'b0;
    bus.out_allowin = 1'b1;
  endtask

  task automatic start_long(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic allow);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.src1        = a;
    bus.src2        = b;
    bus.flush       = 1'b0;
    bus.out_allowin = allow;
  endtask

  // Returns in the first cycle with stall low; bounded so a stuck stall still ends
  task automatic wait_done(output int stalls);
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      else break;
    end
  endtask

  task automatic commit();
    bus.out_allowin = 1'b1;
    @(posedge clk); #1;
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    start_long(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(st);
    chk("mult_stalls", st, 32'd3);
    commit();
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    start_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(st);
    chk("multu_stalls", st, 32'd3);
    commit();
    chk("multu_hi", bus.hi, 32'd1);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    start_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(st);
    chk("div_stalls", st, 32'd33);
    commit();
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    start_long(OP_DIVU, 32'd5, 32'd0, 1'b1);
    wait_done(st);
    commit();
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd5);

    start_long(OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done(st);
    chk("divu_stalls", st, 32'd33);
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_hi", bus.hi, 32'd5);
      chk("hold_lo", bus.lo, 32'hFFFF_FFFF);
      chk("hold_stall", {31'd0, bus.stall}, 32'd0);
    end
    commit();
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    start_long(OP_DIV, 32'd1000, 32'd3, 1'b1);
    repeat (10) @(negedge clk);
    chk("flush_pre_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    idle_in();
    chk("flush_hi", bus.hi, 32'd2);
    chk("flush_lo", bus.lo, 32'd14);
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;

    bus.req_valid = 1'b1;
    bus.req_op    = OP_MTHI;
    bus.src1      = 32'hA5A5_0000;
    @(negedge clk);
    chk("mthi_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.req_op = OP_MFHI;
    bus.src1   = '0;
    @(negedge clk);
    chk("mfhi_rdata", bus.rdata, 32'hA5A5_0000);
    chk("mfhi_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.req_op = OP_MFLO;
    @(negedge clk);
    chk("mflo_rdata", bus.rdata, 32'd14);
    @(posedge clk); #1;

    bus.req_op = OP_MTLO;
    bus.src1   = 32'h0000_1234;
    bus.flush  = 1'b1;
    @(negedge clk);
    chk("mtlo_flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    idle_in();
    chk("mtlo_flush_lo", bus.lo, 32'd14);
    @(posedge clk); #1;

    start_long(OP_MULT, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    chk("rst_pre_stall", {31'd0, bus.stall}, 32'd1);
    #2;
    reset = 1'b1;
    idle_in();
    #1;
    chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    start_long(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done(st);
    chk("post_rst_stalls", st, 32'd3);
    commit();
    chk("post_rst_hi", bus.hi, 32'd1);
    chk("post_rst_lo", bus.lo, 32'd0);
    @(posedge clk); #1;

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
